// File: rtl/mul_m1_pkg.sv
// Shared sizing constants for the M1 multiply stage.
// Every file that needs the datapath width or the register-index width
// imports them from here so there is exactly one place to change them.
package mul_m1_pkg;

    // Datapath width of operands and of the stored result.
    localparam int REG_SIZE = 32;

    // Width of a register-file index (destination register).
    localparam int REG_IDX_W = 5;

endpackage

// File: rtl/mul_m1_core.sv
// Purely combinational multiplier core for the M1 stage.
// It produces the full double-width product and flags whether that product
// fits back into a single register, in either signed or unsigned mode.
module mul_core
    import mul_m1_pkg::*;
#(
    parameter int W = REG_SIZE
) (
    input  logic [W-1:0]   i_srcA,
    input  logic [W-1:0]   i_srcB,
    input  logic           i_isSigned,
    output logic [2*W-1:0] o_product,
    output logic           o_overflow
);

    logic [2*W-1:0] w_extA;
    logic [2*W-1:0] w_extB;
    logic [W:0]     w_upper;

    // Extend both operands to double width (sign or zero), multiply modulo
    // 2^(2W), which is exact for both interpretations, then derive overflow:
    // signed needs the top W+1 bits to be all copies of the sign bit,
    // unsigned needs the upper half to be all zero.
    always_comb begin
        w_extA     = {{W{i_isSigned & i_srcA[W-1]}}, i_srcA};
        w_extB     = {{W{i_isSigned & i_srcB[W-1]}}, i_srcB};
        o_product  = w_extA * w_extB;
        w_upper    = o_product[2*W-1:W-1];
        o_overflow = 1'b0;
        if (i_isSigned) begin
            o_overflow = !((&w_upper) || !(|w_upper));
        end else begin
            o_overflow = |o_product[2*W-1:W];
        end
    end

endmodule

// File: rtl/mul_m1.sv
// M1 pipeline stage of the multiplier: one register stage behind the
// combinational multiply core. Flush beats stall, stall beats load.
// Flags handed to M2 are masked while the stage holds no live instruction.
module mul_m1
    import mul_m1_pkg::*;
#(
    parameter int REG_SIZE = mul_m1_pkg::REG_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [REG_SIZE-1:0]  src_a,
    input  logic [REG_SIZE-1:0]  src_b,
    input  logic                 is_signed,
    input  logic [REG_IDX_W-1:0] pre_dst,
    input  logic                 stall,
    input  logic                 flush,
    output logic [REG_SIZE-1:0]  m1result,
    output logic                 zero,
    output logic                 overflow,
    output logic [REG_IDX_W-1:0] dst,
    output logic                 out_valid
);

    logic [2*REG_SIZE-1:0] w_product;
    logic [REG_SIZE-1:0]   w_productLo;
    logic [REG_SIZE-1:0]   w_unusedProductHi;
    logic                  w_overflow;

    logic [REG_SIZE-1:0]   r_result;
    logic                  r_overflow;
    logic [REG_IDX_W-1:0]  r_dst;
    logic                  r_valid;

    mul_core #(
        .W (REG_SIZE)
    ) u_core (
        .i_srcA     (src_a),
        .i_srcB     (src_b),
        .i_isSigned (is_signed),
        .o_product  (w_product),
        .o_overflow (w_overflow)
    );

    // Only the low word travels down the pipe; the high word is consumed
    // inside the core for the overflow decision.
    assign w_productLo       = w_product[REG_SIZE-1:0];
    assign w_unusedProductHi = w_product[2*REG_SIZE-1:REG_SIZE];

    // Stage register: flush kills validity but keeps data, stall freezes
    // everything, otherwise load on in_valid or drop to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_dst      <= '0;
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                r_result   <= w_productLo;
                r_overflow <= w_overflow;
                r_dst      <= pre_dst;
                r_valid    <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m1result  = r_result;
    assign dst       = r_dst;
    assign out_valid = r_valid;
    assign zero      = r_valid & (r_result == '0);
    assign overflow  = r_valid & r_overflow;

endmodule

// File: tb/tb_mul_m1.sv
// Self-checking bench for the M1 multiply stage.
// A reference model computes the expected stage contents with plain 64-bit
// arithmetic every clock edge and queues them; a monitor pops and compares
// on the falling edge. Directed checks cover the hand-worked cases.
module tb_mul_m1;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          is_signed;
    logic [4:0]    pre_dst;
    logic          stall;
    logic          flush;
    logic [W-1:0]  m1result;
    logic          zero;
    logic          overflow;
    logic [4:0]    dst;
    logic          out_valid;

    int vectors;
    int miscompares;

    typedef struct {
        logic         valid;
        logic [W-1:0] result;
        logic         ovf;
        logic [4:0]   dst;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;

    mul_m1 #(
        .REG_SIZE (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .src_a     (src_a),
        .src_b     (src_b),
        .is_signed (is_signed),
        .pre_dst   (pre_dst),
        .stall     (stall),
        .flush     (flush),
        .m1result  (m1result),
        .zero      (zero),
        .overflow  (overflow),
        .dst       (dst),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply: exact 64-bit product, overflow by range test.
    function automatic void refMultiply(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic s, output logic [W-1:0] lo,
                                        output logic ovf);
        longint          ps;
        longint unsigned pu;
        if (s) begin
            ps  = longint'($signed(a)) * longint'($signed(b));
            lo  = ps[31:0];
            ovf = (ps > 64'sd2147483647) || (ps < -64'sd2147483648);
        end else begin
            pu  = {32'b0, a} * {32'b0, b};
            lo  = pu[31:0];
            ovf = pu > 64'h0000_0000_FFFF_FFFF;
        end
    endfunction

    // Model: expected stage contents after each rising edge go into the queue.
    always @(posedge clk) begin
        exp_t nxt;
        nxt = cur;
        if (!rst_n) begin
            nxt.valid  = 1'b0;
            nxt.result = '0;
            nxt.ovf    = 1'b0;
            nxt.dst    = '0;
        end else if (flush) begin
            nxt.valid = 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                refMultiply(src_a, src_b, is_signed, nxt.result, nxt.ovf);
                nxt.dst   = pre_dst;
                nxt.valid = 1'b1;
            end else begin
                nxt.valid = 1'b0;
            end
        end
        cur <= nxt;
        expQ.push_back(nxt);
    end

    // Monitor: compare every presented output against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        logic expZero;
        logic expOvf;
        if (expQ.size() > 0) begin
            e       = expQ.pop_front();
            expZero = e.valid && (e.result == '0);
            expOvf  = e.valid && e.ovf;
            vectors++;
            if (out_valid !== e.valid || m1result !== e.result || zero !== expZero ||
                overflow !== expOvf || dst !== e.dst) begin
                miscompares++;
                $display("[TB] FAIL scoreboard t=%0t: got v=%0b r=%h z=%0b o=%0b d=%0d, expected v=%0b r=%h z=%0b o=%0b d=%0d",
                         $time, out_valid, m1result, zero, overflow, dst,
                         e.valid, e.result, expZero, expOvf, e.dst);
            end
        end
    end

    // Drive one cycle of inputs just after a rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic [4:0] d,
                                 input logic st, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        src_a     = a;
        src_b     = b;
        is_signed = s;
        pre_dst   = d;
        stall     = st;
        flush     = fl;
    endtask

    // Directed comparison of all outputs against hand-worked values.
    task automatic checkOutput(input string name, input logic [W-1:0] r, input logic z,
                               input logic o, input logic [4:0] d, input logic v);
        vectors++;
        if (m1result !== r || zero !== z || overflow !== o || dst !== d || out_valid !== v) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%0b r=%h z=%0b o=%0b d=%0d, expected v=%0b r=%h z=%0b o=%0b d=%0d",
                     name, out_valid, m1result, zero, overflow, dst, v, r, z, o, d);
        end
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_FFFF;
            4:       return W'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        cur         = '{valid: 1'b0, result: '0, ovf: 1'b0, dst: '0};
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        src_a       = '0;
        src_b       = '0;
        is_signed   = 1'b0;
        pre_dst     = '0;
        stall       = 1'b0;
        flush       = 1'b0;

        #1;
        checkOutput("reset", '0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(1, 32'h0000_FFFF, 32'h0001_0001, 0, 5'd3, 0, 0);
        applyStimulus(0, '0, '0, 0, 5'd0, 0, 0);
        checkOutput("unsigned_basic", 32'hFFFF_FFFF, 0, 0, 5'd3, 1);

        applyStimulus(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 5'd5, 0, 0);
        applyStimulus(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 5'd6, 0, 0);
        checkOutput("signed_min_x_m1", 32'h8000_0000, 0, 1, 5'd5, 1);
        applyStimulus(0, '0, '0, 0, 5'd0, 0, 0);
        checkOutput("unsigned_min_x_max", 32'h8000_0000, 0, 1, 5'd6, 1);

        applyStimulus(1, 32'h0001_0000, 32'h0001_0000, 0, 5'd10, 0, 0);
        applyStimulus(0, '0, '0, 0, 5'd0, 0, 0);
        checkOutput("zero_with_overflow", 32'h0000_0000, 1, 1, 5'd10, 1);

        applyStimulus(1, 32'd3, 32'd4, 0, 5'd7, 0, 0);
        applyStimulus(1, 32'd5, 32'd5, 0, 5'd8, 1, 0);
        checkOutput("stall_hold_1", 32'd12, 0, 0, 5'd7, 1);
        applyStimulus(1, 32'd5, 32'd5, 0, 5'd8, 1, 0);
        checkOutput("stall_hold_2", 32'd12, 0, 0, 5'd7, 1);
        applyStimulus(1, 32'd5, 32'd5, 0, 5'd8, 1, 0);
        checkOutput("stall_hold_3", 32'd12, 0, 0, 5'd7, 1);
        applyStimulus(1, 32'd5, 32'd5, 0, 5'd8, 0, 0);
        checkOutput("stall_hold_4", 32'd12, 0, 0, 5'd7, 1);
        applyStimulus(0, '0, '0, 0, 5'd0, 0, 0);
        checkOutput("stall_release", 32'd25, 0, 0, 5'd8, 1);

        applyStimulus(1, 32'd2, 32'd2, 0, 5'd1, 0, 0);
        applyStimulus(1, 32'd9, 32'd9, 0, 5'd2, 1, 1);
        checkOutput("flush_pre", 32'd4, 0, 0, 5'd1, 1);
        applyStimulus(0, '0, '0, 0, 5'd0, 0, 0);
        checkOutput("flush_over_stall", 32'd4, 0, 0, 5'd1, 0);

        applyStimulus(1, 32'h0000_0000, 32'h1234_5678, 1, 5'd4, 0, 0);
        applyStimulus(0, 32'd1, 32'd1, 0, 5'd9, 0, 0);
        checkOutput("signed_zero", 32'd0, 1, 0, 5'd4, 1);
        applyStimulus(0, '0, '0, 0, 5'd0, 0, 0);
        checkOutput("bubble_masks_zero", 32'd0, 0, 0, 5'd4, 0);

        applyStimulus(1, 32'd7, 32'd6, 0, 5'd9, 0, 0);
        applyStimulus(0, '0, '0, 0, 5'd0, 1, 0);
        checkOutput("pre_async_reset", 32'd42, 0, 0, 5'd9, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", '0, 0, 0, 5'd0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stall = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 0, 0);
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        applyStimulus(0, '0, '0, 0, 5'd0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
